// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: takes parallel words over valid/ready and shifts
// them out one bit at a time. Each bit is held for CLKS_PER_BIT clocks.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   in_data    - word to serialize, sampled on handshake
//   in_valid   - producer has a word
//   in_ready   - serializer can take a word this cycle (combinational)
//   bit_out    - serial data, registered
//   bit_strobe - 1-clk pulse on the first clock of every bit
//   busy       - high while a word is being shifted
//   frame_done - 1-clk pulse after a word's last bit period ends
module seq_bit_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit IDLE_LEVEL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             frame_done
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_nxt;

    logic bit_out_nxt;
    logic bit_strobe_nxt;
    logic busy_nxt;
    logic frame_done_nxt;

    logic period_end;
    logic last_bit;
    logic accept;

    // Bit that leaves the word first, in the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the head bit so the next one moves into the head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign period_end = (state == S_SHIFT) && (div_cnt == DIV_LAST);
    assign last_bit   = (bit_cnt == CNT_LAST);

    // Ready in idle, or on the final clock of the last bit so a
    // following word can start with no gap.
    assign in_ready = !rst &&
                      ((state == S_IDLE) || (period_end && last_bit));
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (period_end && last_bit && !accept) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; outputs are registered below.
    always_comb begin
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        div_cnt_nxt    = div_cnt;
        bit_out_nxt    = bit_out;
        bit_strobe_nxt = 1'b0;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;

        if (accept) begin
            // The head bit goes straight to bit_out; the register keeps
            // the remainder already advanced.
            shreg_nxt      = advance(in_data);
            bit_cnt_nxt    = '0;
            div_cnt_nxt    = '0;
            bit_out_nxt    = head_bit(in_data);
            bit_strobe_nxt = 1'b1;
            busy_nxt       = 1'b1;
            // Back-to-back accept still closes out the previous word.
            frame_done_nxt = (state == S_SHIFT);
        end else if (state == S_SHIFT) begin
            if (!period_end) begin
                div_cnt_nxt = div_cnt + DIV_W'(1);
            end else if (last_bit) begin
                div_cnt_nxt    = '0;
                bit_out_nxt    = IDLE_LEVEL;
                busy_nxt       = 1'b0;
                frame_done_nxt = 1'b1;
            end else begin
                div_cnt_nxt    = '0;
                bit_cnt_nxt    = bit_cnt + CNT_W'(1);
                bit_out_nxt    = head_bit(shreg);
                shreg_nxt      = advance(shreg);
                bit_strobe_nxt = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            bit_out    <= IDLE_LEVEL;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            div_cnt    <= div_cnt_nxt;
            bit_out    <= bit_out_nxt;
            bit_strobe <= bit_strobe_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule
